alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready
// requesters; one transaction in flight, operands and response registered.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [CTRL_W-1:0] req_ctrl0,
  input  logic [CTRL_W-1:0] req_ctrl1,
  input  logic              req_src0,
  input  logic              req_src1,
  input  logic [WIDTH-1:0]  req_rd1_0,
  input  logic [WIDTH-1:0]  req_rd1_1,
  input  logic [WIDTH-1:0]  req_imm0,
  input  logic [WIDTH-1:0]  req_imm1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic [WIDTH-1:0]  alu_rd1,
  output logic [WIDTH-1:0]  alu_imm,
  output logic              alu_src,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                grant_q, grant_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]    rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic [WIDTH-1:0]    alu_rd1_q, alu_rd1_d;
  logic [WIDTH-1:0]    alu_imm_q, alu_imm_d;
  logic                alu_src_q, alu_src_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic                winner;

  // Pointer's requester wins if it is asking, otherwise the other one.
  assign winner = req_valid[ptr_q] ? ptr_q : ~ptr_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    alu_rd1_d    = alu_rd1_q;
    alu_imm_d    = alu_imm_q;
    alu_src_d    = alu_src_q;
    alu_ctrl_d   = alu_ctrl_q;
    req_ready    = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[winner] = 1'b1;
          grant_d    = winner;
          alu_ctrl_d = winner ? req_ctrl1 : req_ctrl0;
          alu_src_d  = winner ? req_src1  : req_src0;
          alu_rd1_d  = winner ? req_rd1_1 : req_rd1_0;
          alu_imm_d  = winner ? req_imm1  : req_imm0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d          = alu_result;
        rsp_zero_d            = alu_zero;
        rsp_valid_d           = 2'b00;
        rsp_valid_d[grant_q]  = 1'b1;
        state_d               = RESP;
      end
      RESP: begin
        // Only the granted requester's accept matters.
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = 2'b00;
          ptr_d       = ~grant_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      grant_q      <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      alu_rd1_q    <= '0;
      alu_imm_q    <= '0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      alu_rd1_q    <= alu_rd1_d;
      alu_imm_q    <= alu_imm_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign alu_rd1    = alu_rd1_q;
  assign alu_imm    = alu_imm_q;
  assign alu_src    = alu_src_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small reference ALU attached.
module tb_alu_share_arbiter;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [CTRL_W-1:0] req_ctrl0, req_ctrl1, alu_ctrl;
  logic              req_src0, req_src1, alu_src, rsp_zero, alu_zero, busy, grant_id;
  logic [WIDTH-1:0]  req_rd1_0, req_rd1_1, req_imm0, req_imm1;
  logic [WIDTH-1:0]  rsp_result, alu_rd1, alu_imm, alu_result, alu_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .req_src0(req_src0), .req_src1(req_src1),
    .req_rd1_0(req_rd1_0), .req_rd1_1(req_rd1_1),
    .req_imm0(req_imm0), .req_imm1(req_imm1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_rd1(alu_rd1), .alu_imm(alu_imm), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id)
  );

  // Reference ALU: and/or/add/sub/slt; ALUSrc=0 has no second register here.
  always_comb begin
    alu_b = alu_src ? alu_imm : '0;
    unique case (alu_ctrl)
      4'b0000: alu_result = alu_rd1 & alu_b;
      4'b0001: alu_result = alu_rd1 | alu_b;
      4'b0010: alu_result = alu_rd1 + alu_b;
      4'b0110: alu_result = alu_rd1 - alu_b;
      4'b0111: alu_result = ($signed(alu_rd1) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_low();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_ctrl0 = '0; req_ctrl1 = '0; req_src0 = 1'b0; req_src1 = 1'b0;
    req_rd1_0 = '0; req_rd1_1 = '0; req_imm0 = '0; req_imm1 = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_grant", grant_id, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    next_low(); rst_n = 1'b1;

    // Single request on port 0: 5 + 7 = 12.
    next_low();
    req_ctrl0 = 4'b0010; req_src0 = 1'b1; req_rd1_0 = 32'd5; req_imm0 = 32'd7;
    req_valid = 2'b01;
    #1 check("single_ready", req_ready, 2'b01);
    next_low(); req_valid = 2'b00;
    #1;
    check("single_busy", busy, 1);
    check("single_grant", grant_id, 0);
    check("single_alu_rd1", alu_rd1, 5);
    check("single_alu_imm", alu_imm, 7);
    check("single_alu_ctrl", alu_ctrl, 4'b0010);
    check("single_alu_src", alu_src, 1);
    check("single_ready_gone", req_ready, 0);
    check("single_no_rsp_yet", rsp_valid, 0);
    next_low(); #1;
    check("single_rsp_valid", rsp_valid, 2'b01);
    check("single_result", rsp_result, 12);
    check("single_zero", rsp_zero, 0);
    next_low(); #1;
    check("single_rsp_hold", rsp_valid, 2'b01);
    check("single_result_hold", rsp_result, 12);
    rsp_ready = 2'b01;
    next_low(); #1;
    check("single_done_valid", rsp_valid, 0);
    check("single_done_busy", busy, 0);
    rsp_ready = 2'b00;

    // Zero flag on port 1: slt 5 < 0 -> 0, zero=1.
    req_ctrl1 = 4'b0111; req_src1 = 1'b1; req_rd1_1 = 32'd5; req_imm1 = 32'd0;
    req_valid = 2'b10;
    #1 check("zero_ready", req_ready, 2'b10);
    next_low(); req_valid = 2'b00;
    #1 check("zero_grant", grant_id, 1);
    next_low(); #1;
    check("zero_rsp_valid", rsp_valid, 2'b10);
    check("zero_result", rsp_result, 0);
    check("zero_flag", rsp_zero, 1);
    rsp_ready = 2'b11;
    next_low(); #1 check("zero_done_busy", busy, 0);

    // Contention: port0 10-3=7, port1 1+2=3; pointer is 0 here.
    req_ctrl0 = 4'b0110; req_src0 = 1'b1; req_rd1_0 = 32'd10; req_imm0 = 32'd3;
    req_ctrl1 = 4'b0010; req_src1 = 1'b1; req_rd1_1 = 32'd1;  req_imm1 = 32'd2;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic exp_g;
      exp_g = k[0];
      #1 check($sformatf("cont%0d_ready", k), req_ready, exp_g ? 2'b10 : 2'b01);
      next_low(); #1;
      check($sformatf("cont%0d_grant", k), grant_id, exp_g);
      check($sformatf("cont%0d_ready_exec", k), req_ready, 0);
      next_low(); #1;
      check($sformatf("cont%0d_rsp_valid", k), rsp_valid, exp_g ? 2'b10 : 2'b01);
      check($sformatf("cont%0d_result", k), rsp_result, exp_g ? 32'd3 : 32'd7);
      next_low();
    end
    req_valid = 2'b00;
    #1 check("cont_end_busy", busy, 0);

    // Backpressure on port 1 while port 0 waits; bit 0 of rsp_ready is ignored.
    rsp_ready = 2'b00;
    req_valid = 2'b10;
    #1 check("bp_ready1", req_ready, 2'b10);
    next_low(); req_valid = 2'b11;
    #1 check("bp_exec_ready", req_ready, 0);
    next_low(); rsp_ready = 2'b01;
    #1 check("bp_rsp_valid", rsp_valid, 2'b10);
    for (int i = 0; i < 5; i++) begin
      next_low(); #1;
      check($sformatf("bp%0d_valid", i), rsp_valid, 2'b10);
      check($sformatf("bp%0d_result", i), rsp_result, 3);
      check($sformatf("bp%0d_zero", i), rsp_zero, 0);
      check($sformatf("bp%0d_busy", i), busy, 1);
      check($sformatf("bp%0d_req_ready", i), req_ready, 0);
    end
    rsp_ready = 2'b10;
    next_low(); rsp_ready = 2'b00;
    #1;
    check("bp_idle_busy", busy, 0);
    check("bp_next_ready", req_ready, 2'b01);
    next_low(); req_valid = 2'b00;
    #1 check("bp_next_grant", grant_id, 0);
    next_low(); #1;
    check("bp_next_valid", rsp_valid, 2'b01);
    check("bp_next_result", rsp_result, 7);
    rsp_ready = 2'b11;
    next_low(); #1 check("bp_done_busy", busy, 0);

    // Reset in EXEC: pointer is 1 now, a lone port-0 request is in flight.
    req_valid = 2'b01;
    next_low(); req_valid = 2'b00;
    #1 check("rx_exec_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rx_busy", busy, 0);
    check("rx_rsp_valid", rsp_valid, 0);
    check("rx_result", rsp_result, 0);
    check("rx_zero", rsp_zero, 0);
    check("rx_alu_rd1", alu_rd1, 0);
    check("rx_alu_imm", alu_imm, 0);
    check("rx_alu_src", alu_src, 0);
    check("rx_alu_ctrl", alu_ctrl, 0);
    check("rx_grant", grant_id, 0);
    check("rx_req_ready", req_ready, 0);
    next_low(); rst_n = 1'b1; rsp_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      next_low(); #1;
      check($sformatf("rx_after%0d_valid", i), rsp_valid, 0);
      check($sformatf("rx_after%0d_busy", i), busy, 0);
    end
    // Pointer must be back at 0 after reset.
    req_valid = 2'b11;
    #1 check("rx_ptr_ready", req_ready, 2'b01);
    next_low(); req_valid = 2'b00;
    #1 check("rx_ptr_grant", grant_id, 0);
    next_low(); #1;
    check("rx_ptr_result", rsp_result, 7);
    rsp_ready = 2'b11;
    next_low(); #1 check("rx_ptr_done", busy, 0);

    // Idle stability: nothing requested for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      next_low(); #1;
      check($sformatf("idle%0d_busy", i), busy, 0);
      check($sformatf("idle%0d_ready", i), req_ready, 0);
      check($sformatf("idle%0d_valid", i), rsp_valid, 0);
      check($sformatf("idle%0d_rd1", i), alu_rd1, 10);
      check($sformatf("idle%0d_imm", i), alu_imm, 3);
      check($sformatf("idle%0d_ctrl", i), alu_ctrl, 4'b0110);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
